// File: rtl/power_rail_sequencer.sv
// Power rail sequencer: brings up ATX, board and MGT rails in order with PG waits
// and timed steps, unwinds them in reverse on power-down, timeout or abort.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   power_up, power_down          single-cycle command strobes
//   power_up_done, power_down_done single-cycle completion strobes
//   busy, seq_fault, fault_step   status and latched timeout info
//   ATX_*, G*_EN, INHIBIT_*, TRACK_2V5, MGT_*  rail controls and PG inputs
module power_rail_sequencer #(
  parameter logic [31:0] STEP_WAIT  = 32'h0003_ffff,
  parameter logic [31:0] PG_TIMEOUT = 32'h003f_ffff
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       power_up,
  input  logic       power_down,
  output logic       power_up_done,
  output logic       power_down_done,
  output logic       busy,
  output logic       seq_fault,
  output logic [3:0] fault_step,
  output logic       ATX_PS_ON_N,
  input  logic       ATX_PWR_OK,
  output logic       G12V_EN,
  output logic       G5V_EN,
  output logic       G3V3_EN,
  output logic       INHIBIT_1V0,
  output logic       INHIBIT_1V2,
  output logic       INHIBIT_1V5,
  output logic       INHIBIT_1V8,
  output logic       INHIBIT_2V5,
  output logic       TRACK_2V5,
  output logic       MGT_AVCC_EN,
  output logic       MGT_AVCCPLL_EN,
  output logic       MGT_AVTTX_EN,
  input  logic       MGT_AVCC_PG,
  input  logic       MGT_AVCCPLL_PG,
  input  logic       MGT_AVTTX_PG
);

  typedef enum logic [1:0] {
    S_OFF,
    S_UP,
    S_ON,
    S_DOWN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [31:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic        seq_fault_q, seq_fault_d;
  logic [3:0]  fault_step_q, fault_step_d;
  logic        up_done_q, up_done_d;
  logic        dn_done_q, dn_done_d;
  logic        busy_q, busy_d;
  logic [9:0]  rails_q, rails_d;
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;

  logic        pg_step;
  logic        pg_sel;
  logic        adv;
  logic        tmo;
  logic [3:0]  lvl;

  always_comb begin
    sync1_d = {MGT_AVTTX_PG, MGT_AVCCPLL_PG,
               MGT_AVCC_PG, ATX_PWR_OK};
    sync2_d = sync1_q;

    pg_step = (step_q == 4'd1) || (step_q >= 4'd8);
    case (step_q)
      4'd1:    pg_sel = sync2_q[0];
      4'd8:    pg_sel = sync2_q[1];
      4'd9:    pg_sel = sync2_q[2];
      4'd10:   pg_sel = sync2_q[3];
      default: pg_sel = 1'b0;
    endcase
    adv = pg_step ? pg_sel : (cnt_q == 32'd0);
    tmo = pg_step && !pg_sel && (cnt_q == 32'd0);

    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    abort_d      = abort_q;
    seq_fault_d  = seq_fault_q;
    fault_step_d = fault_step_q;
    up_done_d    = 1'b0;
    dn_done_d    = 1'b0;

    unique case (state_q)
      S_OFF: begin
        if (power_up && !power_down) begin
          state_d      = S_UP;
          step_d       = 4'd1;
          cnt_d        = PG_TIMEOUT;
          abort_d      = 1'b0;
          seq_fault_d  = 1'b0;
          fault_step_d = 4'd0;
        end
      end
      S_UP: begin
        if (power_down) begin
          state_d = S_DOWN;
          cnt_d   = STEP_WAIT;
          abort_d = 1'b1;
        end else if (adv) begin
          if (step_q == 4'd10) begin
            state_d   = S_ON;
            cnt_d     = 32'd0;
            up_done_d = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
            // steps 8..10 wait on a power-good
            cnt_d  = (step_q >= 4'd7) ? PG_TIMEOUT
                                      : STEP_WAIT;
          end
        end else if (tmo) begin
          state_d      = S_DOWN;
          cnt_d        = STEP_WAIT;
          abort_d      = 1'b1;
          seq_fault_d  = 1'b1;
          fault_step_d = step_q;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_ON: begin
        if (power_down) begin
          state_d = S_DOWN;
          step_d  = 4'd10;
          cnt_d   = STEP_WAIT;
          abort_d = 1'b0;
        end
      end
      S_DOWN: begin
        if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (step_q == 4'd1) begin
          state_d   = S_OFF;
          step_d    = 4'd0;
          dn_done_d = 1'b1;
          // an aborted bring-up also owes its up completion
          up_done_d = abort_q;
          abort_d   = 1'b0;
        end else begin
          step_d = step_q - 4'd1;
          cnt_d  = STEP_WAIT;
        end
      end
      default: state_d = S_OFF;
    endcase

    // number of steps whose rails are applied after this edge
    unique case (state_d)
      S_UP:    lvl = step_d;
      S_ON:    lvl = 4'd10;
      S_DOWN:  lvl = step_d - 4'd1;
      default: lvl = 4'd0;
    endcase
    for (int j = 0; j < 10; j++) begin
      rails_d[j] = (lvl > 4'(j));
    end
    busy_d = (state_d == S_UP) || (state_d == S_DOWN);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_OFF;
      step_q       <= 4'd0;
      cnt_q        <= 32'd0;
      abort_q      <= 1'b0;
      seq_fault_q  <= 1'b0;
      fault_step_q <= 4'd0;
      up_done_q    <= 1'b0;
      dn_done_q    <= 1'b0;
      busy_q       <= 1'b0;
      rails_q      <= 10'd0;
      sync1_q      <= 4'd0;
      sync2_q      <= 4'd0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      seq_fault_q  <= seq_fault_d;
      fault_step_q <= fault_step_d;
      up_done_q    <= up_done_d;
      dn_done_q    <= dn_done_d;
      busy_q       <= busy_d;
      rails_q      <= rails_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
    end
  end

  assign power_up_done   = up_done_q;
  assign power_down_done = dn_done_q;
  assign busy            = busy_q;
  assign seq_fault       = seq_fault_q;
  assign fault_step      = fault_step_q;

  assign ATX_PS_ON_N    = ~rails_q[0];
  assign G12V_EN        = rails_q[1];
  assign G5V_EN         = rails_q[1];
  assign G3V3_EN        = rails_q[1];
  assign INHIBIT_1V0    = ~rails_q[2];
  assign INHIBIT_1V2    = ~rails_q[3];
  assign INHIBIT_1V5    = ~rails_q[4];
  assign INHIBIT_1V8    = ~rails_q[5];
  assign INHIBIT_2V5    = ~rails_q[6];
  assign TRACK_2V5      = rails_q[6];
  assign MGT_AVCC_EN    = rails_q[7];
  assign MGT_AVCCPLL_EN = rails_q[8];
  assign MGT_AVTTX_EN   = rails_q[9];

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Bench for power_rail_sequencer: directed scenarios with literal timing
// plus randomized traffic, all checked every cycle against a rail-count model.
module tb_power_rail_sequencer;

  localparam int SW  = 4;
  localparam int PGT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pu = 1'b0;
  logic       pd = 1'b0;
  logic       atx_ok = 1'b1;
  logic       avcc_pg = 1'b1;
  logic       pll_pg = 1'b1;
  logic       ttx_pg = 1'b1;
  logic       up_done, dn_done, busy, seq_fault;
  logic [3:0] fault_step;
  logic       atx_on_n, g12, g5, g33;
  logic       inh10, inh12, inh15, inh18, inh25, trk;
  logic       avcc_en, pll_en, ttx_en;

  int n_checks = 0;
  int n_errors = 0;

  power_rail_sequencer #(
    .STEP_WAIT (32'd4),
    .PG_TIMEOUT(32'd16)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .power_up       (pu),
    .power_down     (pd),
    .power_up_done  (up_done),
    .power_down_done(dn_done),
    .busy           (busy),
    .seq_fault      (seq_fault),
    .fault_step     (fault_step),
    .ATX_PS_ON_N    (atx_on_n),
    .ATX_PWR_OK     (atx_ok),
    .G12V_EN        (g12),
    .G5V_EN         (g5),
    .G3V3_EN        (g33),
    .INHIBIT_1V0    (inh10),
    .INHIBIT_1V2    (inh12),
    .INHIBIT_1V5    (inh15),
    .INHIBIT_1V8    (inh18),
    .INHIBIT_2V5    (inh25),
    .TRACK_2V5      (trk),
    .MGT_AVCC_EN    (avcc_en),
    .MGT_AVCCPLL_EN (pll_en),
    .MGT_AVTTX_EN   (ttx_en),
    .MGT_AVCC_PG    (avcc_pg),
    .MGT_AVCCPLL_PG (pll_pg),
    .MGT_AVTTX_PG   (ttx_pg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s at %0t: got %h expected %h",
                 name, $time, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 off, 1 up, 2 on, 3 down; rails applied counted as a level
  int       m_mode = 0;
  int       m_cur = 0;
  int       m_el = 0;
  bit       m_abt = 0;
  bit       m_flt = 0;
  int       m_fstep = 0;
  bit       m_upd = 0;
  bit       m_dnd = 0;
  bit [3:0] h1 = 0;
  bit [3:0] h2 = 0;

  function automatic bit is_pg(input int s);
    return (s == 1) || (s >= 8);
  endfunction

  function automatic bit pg_of(input int s, input bit [3:0] v);
    if (s == 1) return v[0];
    if (s == 8) return v[1];
    if (s == 9) return v[2];
    return v[3];
  endfunction

  function automatic logic [20:0] expect_vec();
    int n;
    logic [20:0] v;
    case (m_mode)
      1: n = m_cur;
      2: n = 10;
      3: n = m_cur - 1;
      default: n = 0;
    endcase
    v = {!(n >= 1), n >= 2, n >= 2, n >= 2,
         !(n >= 3), !(n >= 4), !(n >= 5), !(n >= 6),
         !(n >= 7), n >= 7, n >= 8, n >= 9, n >= 10,
         (m_mode == 1) || (m_mode == 3),
         m_upd, m_dnd, m_flt, 4'(m_fstep)};
    return v;
  endfunction

  initial begin
    bit s_rst, s_pu, s_pd, go;
    bit [3:0] s_in, seen;
    logic [20:0] got;
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_pu  = pu;
      s_pd  = pd;
      s_in  = {ttx_pg, pll_pg, avcc_pg, atx_ok};
      #3;
      if (s_rst) begin
        m_mode = 0; m_cur = 0; m_el = 0; m_abt = 0;
        m_flt = 0; m_fstep = 0; m_upd = 0; m_dnd = 0;
        h1 = 0; h2 = 0;
      end else begin
        seen = h2;
        h2 = h1;
        h1 = s_in;
        m_upd = 0;
        m_dnd = 0;
        case (m_mode)
          0: if (s_pu && !s_pd) begin
            m_mode = 1; m_cur = 1; m_el = 0;
            m_flt = 0; m_fstep = 0;
          end
          1: begin
            go = is_pg(m_cur) ? pg_of(m_cur, seen)
                              : (m_el == SW);
            if (s_pd) begin
              m_mode = 3; m_el = 0; m_abt = 1;
            end else if (go) begin
              if (m_cur == 10) begin
                m_mode = 2; m_upd = 1;
              end else begin
                m_cur++; m_el = 0;
              end
            end else if (is_pg(m_cur) && m_el == PGT) begin
              m_flt = 1; m_fstep = m_cur;
              m_mode = 3; m_el = 0; m_abt = 1;
            end else begin
              m_el++;
            end
          end
          2: if (s_pd) begin
            m_mode = 3; m_cur = 10; m_el = 0; m_abt = 0;
          end
          default: begin
            if (m_el == SW) begin
              if (m_cur == 1) begin
                m_mode = 0; m_dnd = 1; m_upd = m_abt;
              end else begin
                m_cur--; m_el = 0;
              end
            end else begin
              m_el++;
            end
          end
        endcase
      end
      got = {atx_on_n, g12, g5, g33, inh10, inh12, inh15,
             inh18, inh25, trk, avcc_en, pll_en, ttx_en,
             busy, up_done, dn_done, seq_fault, fault_step};
      check("cycle_outputs", 32'(got), 32'(expect_vec()));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    check("rst_atx", 32'(atx_on_n), 1);
    check("rst_inh", 32'({inh10, inh12, inh15, inh18, inh25}), 5'h1f);
    check("rst_en", 32'({g12, g5, g33, trk, avcc_en, pll_en, ttx_en}), 0);
    check("rst_stat", 32'({busy, up_done, dn_done, seq_fault, fault_step}), 0);
    rst = 1'b0;
    tick(3);

    // normal power-up, all PGs high
    pu = 1'b1; tick(1); pu = 1'b0;
    check("up_atx_c1", 32'(atx_on_n), 0);
    check("up_busy", 32'(busy), 1);
    tick(1);
    check("up_12v_c2", 32'({g12, g5, g33}), 3'b111);
    tick(4);
    check("up_1v0_c6", 32'(inh10), 1);
    tick(1);
    check("up_1v0_c7", 32'(inh10), 0);
    tick(20);
    check("up_2v5_c27", 32'({inh25, trk}), 2'b01);
    tick(7);
    check("up_ttx_c34", 32'({ttx_en, up_done}), 2'b10);
    tick(1);
    check("up_done_c35", 32'({up_done, busy, seq_fault}), 3'b100);
    tick(1);
    check("up_done_pulse", 32'(up_done), 0);

    // normal power-down
    pd = 1'b1; tick(1); pd = 1'b0;
    check("dn_first", 32'({ttx_en, pll_en, busy}), 3'b011);
    tick(44);
    check("dn_atx_hold", 32'(atx_on_n), 0);
    tick(1);
    check("dn_atx_last", 32'(atx_on_n), 1);
    tick(5);
    check("dn_done", 32'({dn_done, up_done, busy}), 3'b100);
    tick(1);
    check("dn_done_pulse", 32'(dn_done), 0);

    // simultaneous strobes in OFF
    pu = 1'b1; pd = 1'b1; tick(1); pu = 1'b0; pd = 1'b0;
    check("both_off", 32'({atx_on_n, busy, up_done, dn_done}), 4'b1000);
    tick(1);
    check("both_off2", 32'({atx_on_n, busy}), 2'b10);

    // PG timeout on step 9
    pll_pg = 1'b0;
    pu = 1'b1; tick(1); pu = 1'b0;
    check("to_nofault", 32'(seq_fault), 0);
    tick(48);
    check("to_c49", 32'({seq_fault, pll_en}), 2'b01);
    tick(1);
    check("to_c50", 32'({seq_fault, fault_step, pll_en, avcc_en}),
          7'b1_1001_01);
    tick(45);
    check("to_dones", 32'({up_done, dn_done, atx_on_n}), 3'b111);
    tick(1);
    pll_pg = 1'b1;

    // abort during step 4
    pu = 1'b1; tick(1); pu = 1'b0;
    check("ab_clear", 32'({seq_fault, fault_step}), 0);
    tick(12);
    check("ab_step4", 32'(inh12), 0);
    pd = 1'b1; tick(1); pd = 1'b0;
    check("ab_undo4", 32'({inh12, inh10, seq_fault}), 3'b100);
    tick(20);
    check("ab_dones", 32'({up_done, dn_done, seq_fault}), 3'b110);
    tick(1);

    // reset mid-sequence at step 6
    pu = 1'b1; tick(1); pu = 1'b0;
    tick(22);
    check("rs_step6", 32'(inh18), 0);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rs_vals", 32'({atx_on_n, inh18, g12, trk, busy}), 5'b11000);
    tick(3);
    pu = 1'b1; tick(1); pu = 1'b0;
    check("rs_restart", 32'(atx_on_n), 0);
    tick(1);
    check("rs_step2", 32'(g12), 1);
    tick(40);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      pu  = ($urandom_range(0, 7) == 0);
      pd  = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 15) == 0)
        atx_ok = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0)
        avcc_pg = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0)
        pll_pg = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0)
        ttx_pg = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    pu = 1'b0; pd = 1'b0; rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/power_rail_sequencer.md
POWER_RAIL_SEQUENCER -- requirements
Module: power_rail_sequencer

Interface
REQ-001 SHALL have parameter STEP_WAIT, default 32'h0003_ffff, cycles held at each timed step.
REQ-002 SHALL have parameter PG_TIMEOUT, default 32'h003f_ffff, maximum cycles to wait for a power-good.
REQ-003 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports power_up, power_down  in  1 each  single-cycle command strobes from the power manager.
REQ-006 SHALL have ports power_up_done, power_down_done  out  1 each  single-cycle completion strobes.
REQ-007 SHALL have ports busy  out  1  high while not in OFF or ON; seq_fault  out  1  latched timeout flag; fault_step  out  4  step index at which the timeout occurred.
REQ-008 SHALL have ports ATX_PS_ON_N out 1, ATX_PWR_OK in 1, G12V_EN, G5V_EN, G3V3_EN out 1 each, INHIBIT_1V0, INHIBIT_1V2, INHIBIT_1V5, INHIBIT_1V8, INHIBIT_2V5 out 1 each, TRACK_2V5 out 1.
REQ-009 SHALL have ports MGT_AVCC_EN, MGT_AVCCPLL_EN, MGT_AVTTX_EN out 1 each, and MGT_AVCC_PG, MGT_AVCCPLL_PG, MGT_AVTTX_PG in 1 each.

Function
REQ-010 SHALL pass ATX_PWR_OK and the three MGT PG inputs through 2-flop synchronisers; all PG decisions use the synchronised values.
REQ-011 SHALL implement states OFF, UP, ON, DOWN, plus a 4-bit step index 1..10 and a 32-bit down-counter.
REQ-012 SHALL use the following up steps, each asserting its rail outputs on step entry: 1 ATX_PS_ON_N=0 (PG wait on ATX_PWR_OK); 2 G12V/G5V/G3V3_EN=1; 3 INHIBIT_1V0=0; 4 INHIBIT_1V2=0; 5 INHIBIT_1V5=0; 6 INHIBIT_1V8=0; 7 INHIBIT_2V5=0 and TRACK_2V5=1; 8 MGT_AVCC_EN=1 (PG wait); 9 MGT_AVCCPLL_EN=1 (PG wait); 10 MGT_AVTTX_EN=1 (PG wait).
REQ-013 SHALL, on a timed step, load the counter with STEP_WAIT on entry and advance on the cycle after the counter reads 0, giving STEP_WAIT+1 cycles per step.
REQ-014 SHALL, on a PG step, load the counter with PG_TIMEOUT, advance on the cycle after the synchronised PG reads 1, and declare a timeout when the counter reaches 0 with PG still 0.
REQ-015 SHALL, when power_up is sampled in OFF, enter UP step 1 with ATX_PS_ON_N low on the following cycle.
REQ-016 SHALL, on completion of step 10, enter ON and pulse power_up_done for one cycle.
REQ-017 SHALL, when power_down is sampled in ON, enter DOWN and undo the steps in order 10 down to 1, each held for STEP_WAIT+1 cycles with no PG checks.
REQ-018 SHALL, after undoing step 1 (ATX_PS_ON_N=1), enter OFF and pulse power_down_done for one cycle.
REQ-019 SHALL, on a timeout, set seq_fault=1, set fault_step to the current step, and enter DOWN starting from the current step.
REQ-020 SHALL, when a timeout-initiated DOWN completes, pulse power_up_done and power_down_done in the same cycle so the upstream never stalls.
REQ-021 SHALL, when power_down is sampled during UP, enter DOWN from the current step with no fault; the completion pulses follow REQ-020.
REQ-022 SHALL ignore power_up outside OFF and ignore power_down in OFF or DOWN; when both strobes arrive in the same cycle, power_down takes priority.
REQ-023 SHALL clear seq_fault and fault_step on an accepted power_up.

Reset
REQ-024 SHALL, when wb_rst_i=1 in any state including mid-sequence, on the next edge enter OFF with ATX_PS_ON_N=1, all *_EN=0, all INHIBIT_*=1, TRACK_2V5=0, busy=0, done strobes 0, seq_fault=0, fault_step=0, counter=0, and synchronisers cleared.

Verification (STEP_WAIT=4, PG_TIMEOUT=16)
REQ-025 SHALL cover a normal power-up: all PGs high, power_up at cycle 0 -> ATX_PS_ON_N=0 at cycle 1, steps 2-7 spaced 5 cycles apart, power_up_done single pulse, seq_fault=0.
REQ-026 SHALL cover a normal power-down: power_down in ON -> MGT_AVTTX_EN drops first and ATX_PS_ON_N=1 last, 5 cycles per step, power_down_done single pulse, busy=0 afterwards.
REQ-027 SHALL cover a PG timeout: MGT_AVCCPLL_PG held 0 -> after 17 cycles in step 9, seq_fault=1, fault_step=9, reverse sequence from step 9, then power_up_done and power_down_done pulse together.
REQ-028 SHALL cover an abort: power_down during step 4 -> INHIBIT_1V2 returns to 1 and steps 3..1 unwind, seq_fault=0, both done strobes pulse at the end.
REQ-029 SHALL cover reset mid-sequence: wb_rst_i at step 6 -> all outputs at REQ-024 values on the next edge; a subsequent power_up restarts at step 1.
REQ-030 SHALL cover simultaneous strobes: power_up and power_down together in OFF -> no output changes and no done strobes.
